// File: rtl/mod997_unscale.sv
// -----------------------------------------------------------------------------
// mod997_unscale
//
// Removes a power-of-two weight from a mod-997 residue, producing
// (in_res * 2^-in_k) mod MOD. This is the inverse of the forward chunk LUTs,
// which produce (x * 2^k) mod MOD. The block performs one modular halving per
// clock, so a request takes in_k cycles in RUN before the result is offered.
//
// Build option:
//   MOD997_PREREDUCE_EN  defined   : an in_res >= MOD is reduced once at accept
//                                    (in_res - MOD). out_err is always 0.
//                        undefined : an in_res >= MOD is rejected. The block goes
//                                    straight to DONE with out_res=0, out_err=1.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   request valid
//   in_ready   block can accept a request (IDLE only, low during reset)
//   in_res     residue to unscale
//   in_k       number of halvings (weight exponent to remove)
//   out_valid  result valid (DONE state)
//   out_ready  downstream accepts the result
//   out_res    (in_res * 2^-in_k) mod MOD, always in 0..MOD-1
//   out_err    input residue was out of range (default build only)
// -----------------------------------------------------------------------------
module mod997_unscale #(
    parameter int MOD = 997,
    parameter int W   = 10,
    parameter int K_W = 10
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_res,
    input  logic [K_W-1:0] in_k,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_res,
    output logic           out_err
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [W:0]   MOD_X = (W+1)'(MOD);
    localparam logic [W-1:0] MOD_W = W'(MOD);

    state_t         state, state_d;
    logic [W-1:0]   acc, acc_d;
    logic [W-1:0]   res_q, res_d;
    logic [K_W-1:0] cnt, cnt_d;
    logic           err, err_d;
    logic           live;

    logic [W:0]     sum;
    logic [W-1:0]   half;
    logic           in_range;
    logic [W-1:0]   load_val;
    logic           load_err;
    logic           skip_run;

    // One modular halving: an odd residue is made even by adding the odd
    // modulus, then shifted. The sum needs one extra bit, and the result of
    // (acc + MOD) / 2 with acc < MOD is always below MOD.
    assign sum  = {1'b0, acc} + MOD_X;
    assign half = acc[0] ? sum[W:1] : {1'b0, acc[W-1:1]};

    assign in_range = (in_res < MOD_W);

    // Value loaded into the accumulator at accept, and whether the request is
    // rejected. Since 2*MOD > 2^W, a single subtraction always lands in range.
`ifdef MOD997_PREREDUCE_EN
    assign load_val = in_range ? in_res : (in_res - MOD_W);
    assign load_err = 1'b0;
`else
    assign load_val = in_range ? in_res : '0;
    assign load_err = ~in_range;
`endif

    // A zero shift or a rejected input needs no halvings at all.
    assign skip_run = load_err || (in_k == '0);

    // Next-state and handshake logic. The result register res_q is only
    // written on entry to DONE so out_res stays put while a new request runs.
    always_comb begin
        state_d   = state;
        acc_d     = acc;
        cnt_d     = cnt;
        err_d     = err;
        res_d     = res_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        case (state)
            IDLE: begin
                in_ready = live;
                if (in_valid && live) begin
                    acc_d = load_val;
                    err_d = load_err;
                    cnt_d = load_err ? '0 : in_k;
                    if (skip_run) begin
                        res_d   = load_val;
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end

            RUN: begin
                acc_d = half;
                cnt_d = cnt - 1'b1;
                if (cnt == K_W'(1)) begin
                    res_d   = half;
                    state_d = DONE;
                end
            end

            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers. 'live' keeps in_ready low for the first
    // cycle out of reset so nothing is accepted while reset is releasing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            err   <= 1'b0;
            res_q <= '0;
            live  <= 1'b0;
        end else begin
            state <= state_d;
            acc   <= acc_d;
            cnt   <= cnt_d;
            err   <= err_d;
            res_q <= res_d;
            live  <= 1'b1;
        end
    end

    assign out_res = res_q;
    assign out_err = err;

endmodule

// File: tb/tb_mod997_unscale.sv
// -----------------------------------------------------------------------------
// tb_mod997_unscale
//
// Directed bench for mod997_unscale. Each scenario is its own task with
// inline comparisons; expected values are hand-computed constants or come
// from forward multiplication by 2^k mod 997 (the inverse of the DUT's
// operation). Latency is counted in clock edges including the accept edge,
// so a request with shift k reports out_valid after k+1 edges.
// Honours MOD997_PREREDUCE_EN to select the out-of-range expectations.
// -----------------------------------------------------------------------------
module tb_mod997_unscale;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [9:0] in_res = '0;
    logic [9:0] in_k = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [9:0] out_res;
    logic       out_err;

    int n_cmp = 0;
    int n_fail = 0;

    mod997_unscale #(.MOD(997), .W(10), .K_W(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_res    (in_res),
        .in_k      (in_k),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_err   (out_err)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Hard stop in case something blocks forever
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Forward weighting: (r * 2^k) mod 997 by repeated doubling
    function automatic int mul_pow2(input int r, input int k);
        int x;
        x = r;
        for (int i = 0; i < k; i++) x = (x * 2) % 997;
        return x;
    endfunction

    // Advance one clock and settle just after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for in_ready, then present one request for one edge
    task automatic send(input int res, input int k, output bit ok);
        int waited;
        waited = 0;
        while (!in_ready && waited < 50) begin
            step();
            waited++;
        end
        ok = in_ready;
        if (ok) begin
            in_valid = 1'b1;
            in_res   = res[9:0];
            in_k     = k[9:0];
            step();
            in_valid = 1'b0;
        end
    endtask

    // Count edges (accept edge = 1) until out_valid, bounded by limit
    task automatic wait_valid(input int limit, output int lat);
        lat = 1;
        while (!out_valid && lat < limit) begin
            step();
            lat++;
        end
    endtask

    // Complete the output handshake over one edge
    task automatic release_result();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_in_ready: got %0b expected 0", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid: got %0b expected 0", out_valid); end
        n_cmp++; if (out_res !== 10'd0) begin n_fail++; $display("[TB] FAIL reset_out_res: got %0d expected 0", out_res); end
        n_cmp++; if (out_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_err: got %0b expected 0", out_err); end
        step();
        rst_n = 1'b1;
        step();
        step();
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL idle_in_ready: got %0b expected 1", in_ready); end
    endtask

    task automatic test_halve_one();
        bit ok;
        int lat;
        send(2, 1, ok);
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("[TB] FAIL halve_accept: got %0b expected 1", ok); end
        wait_valid(10, lat);
        n_cmp++; if (lat != 2) begin n_fail++; $display("[TB] FAIL halve_latency: got %0d expected 2", lat); end
        n_cmp++; if (out_res !== 10'd1) begin n_fail++; $display("[TB] FAIL halve_res: got %0d expected 1", out_res); end
        n_cmp++; if (out_err !== 1'b0) begin n_fail++; $display("[TB] FAIL halve_err: got %0b expected 0", out_err); end
        release_result();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL halve_valid_drop: got %0b expected 0", out_valid); end
    endtask

    task automatic test_two_halvings();
        bit ok;
        int lat;
        send(1, 2, ok);
        wait_valid(10, lat);
        n_cmp++; if (lat != 3) begin n_fail++; $display("[TB] FAIL two_latency: got %0d expected 3", lat); end
        n_cmp++; if (out_res !== 10'd748) begin n_fail++; $display("[TB] FAIL two_res: got %0d expected 748", out_res); end
        release_result();
    endtask

    task automatic test_passthrough_stall();
        bit ok;
        int lat;
        send(996, 0, ok);
        wait_valid(10, lat);
        n_cmp++; if (lat != 1) begin n_fail++; $display("[TB] FAIL pass_latency: got %0d expected 1", lat); end
        n_cmp++; if (out_res !== 10'd996) begin n_fail++; $display("[TB] FAIL pass_res: got %0d expected 996", out_res); end
        // A competing request during the stall must be ignored
        in_valid = 1'b1;
        in_res   = 10'd3;
        in_k     = 10'd0;
        for (int i = 0; i < 5; i++) begin
            step();
            n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL stall_valid[%0d]: got %0b expected 1", i, out_valid); end
            n_cmp++; if (out_res !== 10'd996) begin n_fail++; $display("[TB] FAIL stall_res[%0d]: got %0d expected 996", i, out_res); end
            n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_in_ready[%0d]: got %0b expected 0", i, in_ready); end
        end
        in_valid = 1'b0;
        release_result();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_release_valid: got %0b expected 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL stall_release_ready: got %0b expected 1", in_ready); end
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_no_dup: got %0b expected 0", out_valid); end
    endtask

    task automatic test_out_of_range();
        bit ok;
        int lat;
        send(1023, 1, ok);
        wait_valid(10, lat);
`ifdef MOD997_PREREDUCE_EN
        // 1023 - 997 = 26, halved once = 13
        n_cmp++; if (lat != 2) begin n_fail++; $display("[TB] FAIL oor_latency: got %0d expected 2", lat); end
        n_cmp++; if (out_res !== 10'd13) begin n_fail++; $display("[TB] FAIL oor_res: got %0d expected 13", out_res); end
        n_cmp++; if (out_err !== 1'b0) begin n_fail++; $display("[TB] FAIL oor_err: got %0b expected 0", out_err); end
`else
        n_cmp++; if (lat != 1) begin n_fail++; $display("[TB] FAIL oor_latency: got %0d expected 1", lat); end
        n_cmp++; if (out_res !== 10'd0) begin n_fail++; $display("[TB] FAIL oor_res: got %0d expected 0", out_res); end
        n_cmp++; if (out_err !== 1'b1) begin n_fail++; $display("[TB] FAIL oor_err: got %0b expected 1", out_err); end
`endif
        release_result();
    endtask

    task automatic test_reset_abort();
        bit ok;
        bit seen;
        int lat;
        send(5, 20, ok);
        repeat (6) step();
        rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_run_valid: got %0b expected 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_run_ready: got %0b expected 0", in_ready); end
        step();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (out_valid) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_no_partial: got %0b expected 0", seen); end
        send(4, 2, ok);
        wait_valid(10, lat);
        n_cmp++; if (lat != 3) begin n_fail++; $display("[TB] FAIL abort_next_latency: got %0d expected 3", lat); end
        n_cmp++; if (out_res !== 10'd1) begin n_fail++; $display("[TB] FAIL abort_next_res: got %0d expected 1", out_res); end
        release_result();
        // Abort while the result is being offered
        send(7, 0, ok);
        wait_valid(10, lat);
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL abort_done_pre: got %0b expected 1", out_valid); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_done_valid: got %0b expected 0", out_valid); end
        step();
        rst_n = 1'b1;
        step();
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_done_after: got %0b expected 0", out_valid); end
    endtask

    task automatic test_max_k();
        bit ok;
        int lat;
        send(1, 1023, ok);
        wait_valid(1100, lat);
        n_cmp++; if (lat != 1024) begin n_fail++; $display("[TB] FAIL maxk_latency: got %0d expected 1024", lat); end
        n_cmp++; if (mul_pow2(int'(out_res), 1023) != 1) begin n_fail++; $display("[TB] FAIL maxk_inverse: got %0d expected 1", mul_pow2(int'(out_res), 1023)); end
        n_cmp++; if (out_res >= 10'd997) begin n_fail++; $display("[TB] FAIL maxk_range: got %0d expected below 997", out_res); end
        release_result();
    endtask

    task automatic test_back_to_back();
        bit ok;
        int lat;
        int r;
        int k;
        int rx;
        rx = 0;
        for (int i = 0; i < 40; i++) begin
            r = (i == 0) ? 0 : (i == 1) ? 996 : int'($urandom_range(0, 996));
            k = (i % 8 == 3) ? 0 : int'($urandom_range(1, 40));
            send(r, k, ok);
            n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_accept[%0d]: got %0b expected 1", i, ok); end
            wait_valid(k + 5, lat);
            if (out_valid) rx++;
            n_cmp++; if (lat != k + 1) begin n_fail++; $display("[TB] FAIL b2b_latency[%0d]: got %0d expected %0d", i, lat, k + 1); end
            n_cmp++; if (mul_pow2(int'(out_res), k) != r) begin n_fail++; $display("[TB] FAIL b2b_inverse[%0d]: got %0d expected %0d", i, mul_pow2(int'(out_res), k), r); end
            n_cmp++; if (out_err !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_err[%0d]: got %0b expected 0", i, out_err); end
            repeat ($urandom_range(0, 3)) step();
            n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_hold[%0d]: got %0b expected 1", i, out_valid); end
            release_result();
            n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_drop[%0d]: got %0b expected 0", i, out_valid); end
        end
        n_cmp++; if (rx != 40) begin n_fail++; $display("[TB] FAIL b2b_count: got %0d expected 40", rx); end
    endtask

    initial begin
        test_reset();
        test_halve_one();
        test_two_halvings();
        test_passthrough_stall();
        test_out_of_range();
        test_reset_abort();
        test_max_k();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
